// File: rtl/noc_inject_arbiter.sv
// ---------------------------------------------------------------------------
// noc_inject_arbiter
//
// Shares one router local injection port between N_REQ on-tile requesters.
// Arbitration is round-robin at packet granularity: once a requester's first
// flit is accepted without 'last', the port stays locked to it until its last
// flit (or until the packet reaches MAX_FLITS, which forces a release and
// raises a sticky error). Accepted flits pass through one output register
// that holds while the router is not ready and can be reloaded in the same
// cycle it drains, giving 1 flit/cycle back-to-back.
//
// Ports
//   clk            in   system clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   req_valid      in   [N_REQ]        requester i offers a flit
//   req_last       in   [N_REQ]        offered flit ends its packet
//   req_data       in   [N_REQ*PKT_W]  offered flits, slice i for requester i
//   req_ready      out  [N_REQ]        flit of requester i accepted this cycle
//   net_data       out  [PKT_W]        flit to router, zero when empty
//   net_valid      out                 net_data holds a flit
//   network_ready  in                  router can take a flit this cycle
//   grant_id       out  [clog2(N_REQ)] current / most recent granted requester
//   busy           out                 packet in progress (LOCKED)
//   err_overlength out                 sticky, a packet hit MAX_FLITS w/o last
// ---------------------------------------------------------------------------
`ifndef PL
`define PL 32
`endif

module noc_inject_arbiter #(
    parameter int N_REQ     = 4,
    parameter int PKT_W     = `PL,
    parameter int MAX_FLITS = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ-1:0]           req_last,
    input  logic [N_REQ*PKT_W-1:0]     req_data,
    output logic [N_REQ-1:0]           req_ready,
    output logic [PKT_W-1:0]           net_data,
    output logic                       net_valid,
    input  logic                       network_ready,
    output logic [$clog2(N_REQ)-1:0]   grant_id,
    output logic                       busy,
    output logic                       err_overlength
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(MAX_FLITS + 1);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]    grant_q, grant_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             nv_q, nv_d;
    logic [PKT_W-1:0] nd_q, nd_d;
    logic             err_q, err_d;

    logic             stage_free;
    logic             win_found;
    logic [IW-1:0]    win_idx;
    logic [IW-1:0]    sel_idx;
    logic [PKT_W-1:0] sel_data;
    logic             sel_last;
    logic             accept;
    logic [CW-1:0]    cnt_inc;

    // The output register can take a new flit when empty or draining now.
    assign stage_free = !nv_q || network_ready;

    // Round-robin search starting just after the last packet's owner.
    always_comb begin
        int cand;
        cand      = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = (int'(rr_ptr_q) + k) % N_REQ;
            if (!win_found && req_valid[IW'(cand)]) begin
                win_found = 1'b1;
                win_idx   = IW'(cand);
            end
        end
    end

    // While locked only the owner may move; otherwise the fresh winner.
    assign sel_idx = (state_q == IDLE) ? win_idx : grant_q;

    always_comb begin
        req_ready = '0;
        if (state_q == IDLE) begin
            if (win_found) begin
                req_ready[win_idx] = stage_free;
            end
        end else begin
            req_ready[grant_q] = stage_free;
        end
    end

    assign accept = |(req_ready & req_valid);

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (sel_idx == IW'(i)) begin
                sel_data = req_data[i*PKT_W +: PKT_W];
            end
        end
    end

    assign sel_last = req_last[sel_idx];
    assign cnt_inc  = cnt_q + CW'(1);

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        cnt_d    = cnt_q;
        nv_d     = nv_q;
        nd_d     = nd_q;
        err_d    = err_q;

        if (accept) begin
            // Load replaces any flit draining this same cycle.
            nv_d = 1'b1;
            nd_d = sel_data;
            if (state_q == IDLE) begin
                grant_d = sel_idx;
                cnt_d   = CW'(1);
                if (sel_last) begin
                    rr_ptr_d = sel_idx;
                end else begin
                    state_d = LOCKED;
                end
            end else begin
                cnt_d = cnt_inc;
                if (sel_last) begin
                    state_d  = IDLE;
                    rr_ptr_d = grant_q;
                end else if (cnt_inc == CW'(MAX_FLITS)) begin
                    // Forced release: the rest of this stream re-arbitrates
                    // as a new packet.
                    err_d    = 1'b1;
                    state_d  = IDLE;
                    rr_ptr_d = grant_q;
                end
            end
        end else if (network_ready) begin
            nv_d = 1'b0;
            nd_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= IW'(N_REQ - 1);
            grant_q  <= '0;
            cnt_q    <= '0;
            nv_q     <= 1'b0;
            nd_q     <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            cnt_q    <= cnt_d;
            nv_q     <= nv_d;
            nd_q     <= nd_d;
            err_q    <= err_d;
        end
    end

    assign net_data       = nd_q;
    assign net_valid      = nv_q;
    assign grant_id       = grant_q;
    assign busy           = (state_q == LOCKED);
    assign err_overlength = err_q;

endmodule

// File: tb/tb_noc_inject_arbiter.sv
// ---------------------------------------------------------------------------
// Bench for noc_inject_arbiter (N_REQ=4, PKT_W=16, MAX_FLITS=4).
// Each requester is fed from its own flit queue; each test pushes the flit
// order it expects on the router side into a scoreboard queue, which is
// popped and compared whenever a flit leaves the output register.
// ---------------------------------------------------------------------------
module tb_noc_inject_arbiter;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int MF = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_last;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic [W-1:0]   net_data;
    logic           net_valid;
    logic           network_ready;
    logic [1:0]     grant_id;
    logic           busy;
    logic           err_overlength;

    always #5 clk = ~clk;

    noc_inject_arbiter #(
        .N_REQ    (N),
        .PKT_W    (W),
        .MAX_FLITS(MF)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_last      (req_last),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .net_data      (net_data),
        .net_valid     (net_valid),
        .network_ready (network_ready),
        .grant_id      (grant_id),
        .busy          (busy),
        .err_overlength(err_overlength)
    );

    logic [W:0]   srcq [N][$];   // {last, data} per requester
    logic [W-1:0] expq [$];      // expected router-side flit order
    int n_cmp = 0;
    int n_bad = 0;

    task automatic push(input int r, input logic [W-1:0] d, input logic l);
        srcq[r].push_back({l, d});
    endtask

    task automatic drive_inputs();
        logic [W:0] h;
        for (int i = 0; i < N; i++) begin
            if (srcq[i].size() != 0) begin
                h = srcq[i][0];
                req_valid[i]       = 1'b1;
                req_last[i]        = h[W];
                req_data[i*W +: W] = h[W-1:0];
            end else begin
                req_valid[i]       = 1'b0;
                req_last[i]        = 1'b0;
                req_data[i*W +: W] = '0;
            end
        end
        #1;
    endtask

    // One clock: sample handshakes and departing flit mid-cycle, then advance.
    task automatic step();
        logic [N-1:0] acc;
        logic [W-1:0] e;
        @(negedge clk);
        acc = req_valid & req_ready;
        if (net_valid && network_ready) begin
            n_cmp++;
            if (expq.size() == 0) begin
                n_bad++;
                $display("FAIL sb_flit: got %h, required no flit", net_data);
            end else begin
                e = expq.pop_front();
                if (net_data !== e) begin
                    n_bad++;
                    $display("FAIL sb_flit: got %h, required %h", net_data, e);
                end
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) if (acc[i]) void'(srcq[i].pop_front());
        drive_inputs();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) srcq[i].delete();
        expq.delete();
        network_ready = 1'b1;
        drive_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (net_valid !== 1'b0) begin n_bad++; $display("FAIL rst_net_valid: got %b, required 0", net_valid); end
        n_cmp++; if (net_data !== '0) begin n_bad++; $display("FAIL rst_net_data: got %h, required 0", net_data); end
        n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL rst_req_ready: got %b, required 0000", req_ready); end
        n_cmp++; if (grant_id !== 2'd0) begin n_bad++; $display("FAIL rst_grant_id: got %0d, required 0", grant_id); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b, required 0", busy); end
        n_cmp++; if (err_overlength !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b, required 0", err_overlength); end
    endtask

    task automatic test_single_packet();
        logic [W-1:0] ed [3];
        logic         eb [3];
        ed = '{16'h00A1, 16'h00A2, 16'h00A3};
        eb = '{1'b1, 1'b1, 1'b0};
        push(0, 16'h00A1, 1'b0);
        push(0, 16'h00A2, 1'b0);
        push(0, 16'h00A3, 1'b1);
        for (int k = 0; k < 3; k++) expq.push_back(ed[k]);
        drive_inputs();
        n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL single_ready: got %b, required 0001", req_ready); end
        for (int k = 0; k < 3; k++) begin
            step();
            n_cmp++; if (net_data !== ed[k]) begin n_bad++; $display("FAIL single_data%0d: got %h, required %h", k, net_data, ed[k]); end
            n_cmp++; if (busy !== eb[k]) begin n_bad++; $display("FAIL single_busy%0d: got %b, required %b", k, busy, eb[k]); end
        end
        step();
        n_cmp++; if (net_valid !== 1'b0 || net_data !== '0) begin n_bad++; $display("FAIL single_drain: got v=%b d=%h, required v=0 d=0000", net_valid, net_data); end
    endtask

    task automatic test_round_robin();
        int eg [5];
        eg = '{0, 1, 2, 3, 0};
        do_reset();
        push(0, 16'h0B00, 1'b1);
        push(0, 16'h0B04, 1'b1);
        push(1, 16'h0B01, 1'b1);
        push(2, 16'h0B02, 1'b1);
        push(3, 16'h0B03, 1'b1);
        expq.push_back(16'h0B00); expq.push_back(16'h0B01); expq.push_back(16'h0B02);
        expq.push_back(16'h0B03); expq.push_back(16'h0B04);
        drive_inputs();
        for (int k = 0; k < 5; k++) begin
            step();
            n_cmp++; if (grant_id !== 2'(eg[k])) begin n_bad++; $display("FAIL rr_grant%0d: got %0d, required %0d", k, grant_id, eg[k]); end
        end
        step();
    endtask

    task automatic test_no_interleave();
        // Last packet was requester 0, so requester 1 wins ahead of 2.
        for (int k = 0; k < 4; k++) begin
            push(1, 16'h0C10 + 16'(k), (k == 3));
            expq.push_back(16'h0C10 + 16'(k));
        end
        push(2, 16'h0C20, 1'b1);
        expq.push_back(16'h0C20);
        drive_inputs();
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL lock_ready%0d: got %b, required 0010", k, req_ready); end
            step();
        end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL lock_busy_end: got %b, required 0", busy); end
        n_cmp++; if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL lock_next_ready: got %b, required 0100", req_ready); end
        step();
        n_cmp++; if (grant_id !== 2'd2 || net_data !== 16'h0C20) begin n_bad++; $display("FAIL lock_next: got g=%0d d=%h, required g=2 d=0c20", grant_id, net_data); end
        step();
    endtask

    task automatic test_backpressure();
        push(3, 16'h0D30, 1'b1);
        push(3, 16'h0D31, 1'b1);
        expq.push_back(16'h0D30);
        expq.push_back(16'h0D31);
        drive_inputs();
        step();
        network_ready = 1'b0;
        #1;
        for (int k = 0; k < 5; k++) begin
            n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL bp_ready%0d: got %b, required 0000", k, req_ready); end
            n_cmp++; if (net_valid !== 1'b1 || net_data !== 16'h0D30) begin n_bad++; $display("FAIL bp_hold%0d: got v=%b d=%h, required v=1 d=0d30", k, net_valid, net_data); end
            step();
        end
        network_ready = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 4'b1000) begin n_bad++; $display("FAIL bp_release_ready: got %b, required 1000", req_ready); end
        step();
        n_cmp++; if (net_valid !== 1'b1 || net_data !== 16'h0D31) begin n_bad++; $display("FAIL bp_no_bubble: got v=%b d=%h, required v=1 d=0d31", net_valid, net_data); end
        step();
        n_cmp++; if (net_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drain: got %b, required 0", net_valid); end
    endtask

    task automatic test_overlength();
        logic [W-1:0] ed [7];
        ed = '{16'h0E01, 16'h0E02, 16'h0E03, 16'h0E04, 16'h0E31, 16'h0E05, 16'h0E06};
        for (int k = 1; k <= 6; k++) push(0, 16'h0E00 + 16'(k), 1'b0);
        push(3, 16'h0E31, 1'b1);
        for (int k = 0; k < 7; k++) expq.push_back(ed[k]);
        drive_inputs();
        for (int k = 0; k < 3; k++) begin
            step();
            n_cmp++; if (err_overlength !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL ovl_pre%0d: got err=%b busy=%b, required err=0 busy=1", k, err_overlength, busy); end
        end
        step();
        n_cmp++; if (err_overlength !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL ovl_force: got err=%b busy=%b, required err=1 busy=0", err_overlength, busy); end
        step();
        n_cmp++; if (grant_id !== 2'd3 || net_data !== 16'h0E31) begin n_bad++; $display("FAIL ovl_next: got g=%0d d=%h, required g=3 d=0e31", grant_id, net_data); end
        step();
        n_cmp++; if (grant_id !== 2'd0 || busy !== 1'b1) begin n_bad++; $display("FAIL ovl_resume: got g=%0d busy=%b, required g=0 busy=1", grant_id, busy); end
        step();
        step();
        n_cmp++; if (err_overlength !== 1'b1) begin n_bad++; $display("FAIL ovl_sticky: got %b, required 1", err_overlength); end
    endtask

    task automatic test_reset_mid_packet();
        // Requester 0 is still locked (2 flits into a packet).
        push(0, 16'h0F01, 1'b0);
        expq.push_back(16'h0F01);
        drive_inputs();
        step();
        network_ready = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b1 || net_valid !== 1'b1) begin n_bad++; $display("FAIL mid_pre: got busy=%b v=%b, required busy=1 v=1", busy, net_valid); end
        for (int i = 0; i < N; i++) srcq[i].delete();
        expq.delete();
        drive_inputs();
        rst_n = 1'b0;
        #1;
        n_cmp++; if (net_valid !== 1'b0 || net_data !== '0) begin n_bad++; $display("FAIL mid_rst_out: got v=%b d=%h, required v=0 d=0000", net_valid, net_data); end
        n_cmp++; if (busy !== 1'b0 || err_overlength !== 1'b0) begin n_bad++; $display("FAIL mid_rst_flags: got busy=%b err=%b, required 0 0", busy, err_overlength); end
        n_cmp++; if (grant_id !== 2'd0 || req_ready !== 4'b0000) begin n_bad++; $display("FAIL mid_rst_grant: got g=%0d rdy=%b, required g=0 rdy=0000", grant_id, req_ready); end
        network_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        push(2, 16'h0F20, 1'b1);
        push(0, 16'h0F00, 1'b1);
        expq.push_back(16'h0F00);
        expq.push_back(16'h0F20);
        drive_inputs();
        n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL mid_prio: got %b, required 0001", req_ready); end
        step();
        n_cmp++; if (grant_id !== 2'd0) begin n_bad++; $display("FAIL mid_grant0: got %0d, required 0", grant_id); end
        step();
        n_cmp++; if (grant_id !== 2'd2) begin n_bad++; $display("FAIL mid_grant2: got %0d, required 2", grant_id); end
        step();
    endtask

    initial begin
        rst_n         = 1'b0;
        network_ready = 1'b1;
        req_valid     = '0;
        req_last      = '0;
        req_data      = '0;
        test_reset();
        test_single_packet();
        test_round_robin();
        test_no_interleave();
        test_backpressure();
        test_overlength();
        test_reset_mid_packet();
        for (int k = 0; k < 20 && expq.size() != 0; k++) step();
        n_cmp++;
        if (expq.size() != 0) begin
            n_bad++;
            $display("FAIL sb_drain: got %0d flits outstanding, required 0", expq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
